// File: rtl/fetch_sequencer.sv
// Program-counter owner and instruction fetch front end: issues imem reads,
// buffers returns in a 2-entry FIFO and flushes wrong-path work on redirect.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter int unsigned PC_STEP      = 2,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [15:0] pc_branch,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc,
    output logic        misalign,
    output logic [15:0] fetch_pc
);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
        $error("FLUSH_CYCLES must be in 1..7");
    end

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    state_e            state_q, state_d;
    logic [15:0]       fetch_pc_q, fetch_pc_d;
    logic [15:0]       tag_pc_q, tag_pc_d;
    logic [2:0]        flush_cnt_q, flush_cnt_d;
    logic [1:0]        count_q, count_d;
    logic              inflight_q, inflight_d;
    logic              misalign_q, misalign_d;
    logic [1:0][15:0]  buf_instr_q, buf_instr_d;
    logic [1:0][15:0]  buf_pc_q, buf_pc_d;

    logic              pop;
    logic              issue;
    logic              wr_idx;
    logic [2:0]        occupancy;

    always_comb begin
        pop       = (count_q != 2'd0) && out_ready;
        // Slots committed after this cycle: buffered + in flight - leaving.
        occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = (state_q == StRun) && !redirect && !reset && (occupancy < 3'd2);
        wr_idx    = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);
    end

    assign imem_rd   = issue;
    assign imem_addr = fetch_pc_q;
    assign fetch_pc  = fetch_pc_q;
    assign out_valid = (count_q != 2'd0);
    assign out_instr = buf_instr_q[0];
    assign out_pc    = buf_pc_q[0];
    assign misalign  = misalign_q;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        tag_pc_d    = tag_pc_q;
        flush_cnt_d = flush_cnt_q;
        count_d     = count_q;
        inflight_d  = issue;
        misalign_d  = redirect & pc_branch[0];
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;

        unique case (state_q)
            StIdle: state_d = StRun;
            StRun:  state_d = StRun;
            StFlush: begin
                flush_cnt_d = flush_cnt_q - 3'd1;
                if (flush_cnt_q == 3'd1) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase

        if (issue) begin
            fetch_pc_d = fetch_pc_q + 16'(PC_STEP);
            tag_pc_d   = fetch_pc_q;
        end

        // Shift on pop first so a same-cycle push lands behind the new head.
        if (pop) begin
            buf_instr_d[0] = buf_instr_q[1];
            buf_pc_d[0]    = buf_pc_q[1];
        end
        if (inflight_q) begin
            buf_instr_d[wr_idx] = imem_data;
            buf_pc_d[wr_idx]    = tag_pc_q;
        end
        count_d = count_q - {1'b0, pop} + {1'b0, inflight_q};

        if (redirect) begin
            fetch_pc_d  = {pc_branch[15:1], 1'b0};
            count_d     = 2'd0;
            inflight_d  = 1'b0;
            state_d     = StFlush;
            flush_cnt_d = 3'(FLUSH_CYCLES);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            fetch_pc_q  <= RESET_PC;
            tag_pc_q    <= 16'h0000;
            flush_cnt_q <= 3'd0;
            count_q     <= 2'd0;
            inflight_q  <= 1'b0;
            misalign_q  <= 1'b0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            tag_pc_q    <= tag_pc_d;
            flush_cnt_q <= flush_cnt_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            misalign_q  <= misalign_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

endmodule
